vga_image_reader: RTL
=====================

Name: vga_image_reader

Overview:
- Display-side consumer of the data memory's VGA read port.
- Generates 640x480@60 VGA timing from a pixel-enable strobe and drives vgaAdress to the memory.
- Samples the returned 8-bit ImageData and outputs a grayscale RGB332 pixel plus hsync/vsync.
- Shows an IMG_W x IMG_H image, upscaled by 2^SCALE_LOG2, anchored top-left; all other visible pixels are black.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
IMG_W, 32, image width in bytes/pixels
IMG_H, 32, image height in lines
SCALE_LOG2, 3, each image pixel is drawn as a 2^SCALE_LOG2 square
IMG_BASE, 0, byte address of image pixel (0,0) in data memory

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
pix_en  in  1  pixel-clock enable, one-cycle strobe (e.g. every 2nd clk)
ImageData  in  8  pixel byte from the data memory, combinational on vgaAdress
vgaAdress  out  32  byte address into the data memory
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
red  out  3  pixel red
green  out  3  pixel green
blue  out  2  pixel blue
frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Reset is synchronous, active-low: sampled only on the clk rising edge while rst==0.
- Reset values:
  - hcnt=0, vcnt=0.
  - vgaAdress=IMG_BASE.
  - hsync=1, vsync=1.
  - red/green/blue=0.
  - frame_start=0.
  - All pipeline registers are cleared.
- All state advances only on clk edges where pix_en==1; with pix_en==0 every register holds.
- Counters:
  - hcnt runs 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800).
  - On hcnt wrap, vcnt increments, running 0..V_TOT-1, where V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
  - vcnt wraps to 0 after V_TOT-1.
- Stage 0 decode, from the current (hcnt,vcnt):
  - hs0 = 0 when H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC, else 1.
  - vs0 = 0 when V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SYNC, else 1.
  - vis0 = (hcnt<H_VIS) && (vcnt<V_VIS).
  - img0 = vis0 && (hcnt>>SCALE_LOG2)<IMG_W && (vcnt>>SCALE_LOG2)<IMG_H.
- Stage 1, registered on the pix_en tick:
  - vgaAdress <= img0 ? IMG_BASE + (vcnt>>SCALE_LOG2)*IMG_W + (hcnt>>SCALE_LOG2) : IMG_BASE.
  - hs1<=hs0, vs1<=vs0, img1<=img0.
  - The address stays in range when the image is not shown.
  - Arithmetic is 32-bit unsigned, with no overflow for legal parameters.
- Stage 2, on the next pix_en tick:
  - hsync<=hs1, vsync<=vs1.
  - If img1: red<=ImageData[7:5], green<=ImageData[7:5], blue<=ImageData[7:6].
  - Else red/green/blue <= 0.
- Latency: the outputs for counter position (h,v) appear exactly 2 pix_en ticks after the counters held (h,v). Sync and colour therefore stay mutually aligned.
- frame_start:
  - Driven high for one clk on the tick where hcnt goes H_TOT-1 -> 0 and vcnt goes V_TOT-1 -> 0.
  - Low otherwise, including cycles with pix_en==0.
- Data memory writes during display are allowed. A pixel shows whatever value ImageData holds at its stage-2 sample edge; no tearing protection is provided.
- Reset mid-frame: the next edge with rst==0 restores all reset values regardless of pix_en.
  - Counting restarts at (0,0) on the first pix_en after rst returns to 1.
  - frame_start is not pulsed for this restart.
- rst has priority over pix_en when both are active on the same edge.

Test Plan:
- Reset, hold rst=0 for 3 clk with pix_en toggling -> hsync=vsync=1, rgb=0, vgaAdress=0, frame_start=0.
- Release rst, pix_en every 2nd clk, count ticks:
  - hsync falls at output tick 658 (656+2).
  - hsync stays low for 96 ticks.
  - Line period is 800 ticks.
- Count lines -> vsync is low for exactly 2 lines (lines 490-491), frame period 525 lines, frame_start pulses once per 420000 ticks.
- Memory model with mem[a]=a[7:0], IMG_BASE=0:
  - Pixel (8,0) -> vgaAdress=1.
  - Pixel (15,9) -> vgaAdress=33.
  - Pixel (255,255) -> vgaAdress=1023.
  - ImageData=0xE0 -> red=7, green=7, blue=3.
- Pixel (256,0), pixel (0,256) and blanking -> rgb=0, vgaAdress=0; pix_en held low 10 clk mid-line -> all outputs and vgaAdress frozen.
- Assert rst for 1 clk at hcnt=300, vcnt=100 -> next edge hsync=vsync=1, rgb=0; after release, the first output hsync falls 658 ticks later and no frame_start occurs before a full frame.

Source files
------------

// File: rtl/vga_image_reader.sv
// VGA raster scanner that fetches image bytes from data memory and emits grayscale RGB332.
// Sync and colour leave the block two pix_en ticks after the counters that produced them.
module vga_image_reader #(
  parameter int unsigned H_VIS      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VIS      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter logic [31:0] IMG_BASE   = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [7:0]  ImageData,
  output logic [31:0] vgaAdress,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, img1_q, img1_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic [2:0]    red_q, red_d, green_q, green_d;
  logic [1:0]    blue_q, blue_d;
  logic          fs_q, fs_d;

  logic          wrap, vis0;
  logic [31:0]   hpix, vpix;
  logic [4:0]    unused_data;

  assign unused_data = ImageData[4:0];

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    wrap   = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
    fs_d = pix_en && wrap;

    hpix   = 32'(hcnt_q) >> SCALE_LOG2;
    vpix   = 32'(vcnt_q) >> SCALE_LOG2;
    vis0   = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    hs1_d  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs1_d  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    img1_d = vis0 && (hpix < IMG_W) && (vpix < IMG_H);
    // Off-image pixels park the address on the image base so it never leaves the image window.
    addr_d = img1_d ? IMG_BASE + vpix * IMG_W + hpix : IMG_BASE;

    hsync_d = hs1_q;
    vsync_d = vs1_q;
    red_d   = img1_q ? ImageData[7:5] : 3'd0;
    green_d = img1_q ? ImageData[7:5] : 3'd0;
    blue_d  = img1_q ? ImageData[7:6] : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      addr_q  <= IMG_BASE;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      img1_q  <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= fs_d;
      if (pix_en) begin
        hcnt_q  <= hcnt_d;
        vcnt_q  <= vcnt_d;
        addr_q  <= addr_d;
        hs1_q   <= hs1_d;
        vs1_q   <= vs1_d;
        img1_q  <= img1_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        red_q   <= red_d;
        green_q <= green_d;
        blue_q  <= blue_d;
      end
    end
  end

  assign vgaAdress   = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = fs_q;

endmodule
